// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: bus widths, the IO address
// and the load/run state encoding.
package cpu_mem_pkg;
  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  function automatic int io_top(input int aw);
    return (1 << aw) - 1;
  endfunction

  localparam int IO_ADDR = io_top(CPU_ADDR_W);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;
endpackage

// File: rtl/cpu_mem_array.sv
// Single-clock RAM with one write port and one registered read port; a read
// colliding with a write to the same cell returns the old contents.
module cpu_mem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [(1 << AW)];
  logic [DW-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the read register is reset; the array keeps its contents.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_q <= '0;
    else       r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder: RAM plus mapped output register for the CPU, and a
// byte-stream loader that fills RAM while holding the CPU in reset.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int addr_width = CPU_ADDR_W,
  parameter int data_width = CPU_DATA_W,
  parameter logic [addr_width-1:0] io_addr = addr_width'(io_top(addr_width))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [data_width-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  cpu_rst,
  output logic                  load_busy,
  output logic [data_width-1:0] io_out,
  output logic                  io_strobe
);
  state_e                  r_state, w_state_nxt;
  logic [addr_width-1:0]   r_ld_ptr, w_ptr_nxt;
  logic [data_width-1:0]   r_io, r_io_snap, w_mem_q;
  logic                    r_io_sel, r_io_strobe;
  logic                    w_run, w_is_io, w_cpu_io_wr;
  logic                    w_we;
  logic [addr_width-1:0]   w_waddr;
  logic [data_width-1:0]   w_wdata;

  assign w_run       = (r_state == ST_RUN);
  assign w_is_io     = (addr == io_addr);
  assign w_cpu_io_wr = w_run && write && w_is_io;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ld_ptr;
    ld_ready    = 1'b0;
    cpu_rst     = 1'b1;
    load_busy   = 1'b0;
    case (r_state)
      ST_HOLD: if (ld_start) begin
        w_state_nxt = ST_LOAD;
        w_ptr_nxt   = '0;
      end
      ST_LOAD: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
        if (ld_valid) begin
          w_ptr_nxt = r_ld_ptr + 1'b1;
          if (ld_last) w_state_nxt = ST_RELEASE;
        end
        // A restart overrides the increment of a same-cycle byte.
        if (ld_start) w_ptr_nxt = '0;
      end
      ST_RELEASE: begin
        load_busy   = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cpu_rst = 1'b0;
        if (ld_start) begin
          w_state_nxt = ST_LOAD;
          w_ptr_nxt   = '0;
        end
      end
      default: w_state_nxt = ST_HOLD;
    endcase
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = addr;
    w_wdata = wdata;
    if (r_state == ST_LOAD) begin
      w_we    = ld_valid;
      w_waddr = r_ld_ptr;
      w_wdata = ld_data;
    end else if (w_run) begin
      w_we = write && !w_is_io;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HOLD;
      r_ld_ptr    <= '0;
      r_io        <= '0;
      r_io_snap   <= '0;
      r_io_sel    <= 1'b0;
      r_io_strobe <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ld_ptr    <= w_ptr_nxt;
      r_io_strobe <= w_cpu_io_wr;
      if (w_cpu_io_wr) r_io <= wdata;
      // Snapshot the pre-write value so an IO read colliding with an IO write sees old data.
      r_io_snap   <= r_io;
      r_io_sel    <= w_is_io;
    end
  end

  cpu_mem_array #(.AW(addr_width), .DW(data_width)) u_mem (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (addr),
    .o_rdata (w_mem_q)
  );

  assign rdata     = r_io_sel ? r_io_snap : w_mem_q;
  assign io_out    = r_io;
  assign io_strobe = r_io_strobe;
endmodule
